// File: rtl/layer_pool_sequencer.sv
// layer_pool_sequencer: launches each CNN layer engine in turn, waits for its
// calculation-done and forwards the active engine's output writes onto the
// single shared feature-map write port.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               run the full layer chain (only honoured when idle)
//   layer_start         one-hot, one-cycle launch pulse per engine
//   layer_done          per-engine calculation_done
//   layer_save_enable   per-engine save_enable
//   layer_row/col/data  per-engine output word, engine i at [i*W +: W]
//   mem_we/row/col/wdata/layer  shared feature-map write port (1-cycle latency)
//   busy                high whenever not idle
//   all_done            one-cycle pulse when the last layer completes
//   write_count         writes issued for the current/last layer (saturating)
//   error, err_code     sticky error; bit0 watchdog, bit1 done from inactive layer
module layer_pool_sequencer #(
   parameter int unsigned NUM_LAYERS     = 4,
   parameter int unsigned DATA_W         = 128,
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   localparam int unsigned LAYER_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic [NUM_LAYERS-1:0]        layer_start,
   input  logic [NUM_LAYERS-1:0]        layer_done,
   input  logic [NUM_LAYERS-1:0]        layer_save_enable,
   input  logic [NUM_LAYERS*ADDR_W-1:0] layer_row,
   input  logic [NUM_LAYERS*ADDR_W-1:0] layer_col,
   input  logic [NUM_LAYERS*DATA_W-1:0] layer_data,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_row,
   output logic [ADDR_W-1:0]            mem_col,
   output logic [DATA_W-1:0]            mem_wdata,
   output logic [LAYER_W-1:0]           mem_layer,
   output logic                         busy,
   output logic                         all_done,
   output logic [15:0]                  write_count,
   output logic                         error,
   output logic [1:0]                   err_code
);

   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_NEXT, S_FINISH} state_t;

   state_t                  state_q, state_d;
   logic [LAYER_W-1:0]      cur_q, cur_d;
   logic [WD_W-1:0]         wd_q, wd_d;
   logic [NUM_LAYERS-1:0]   layer_start_d;
   logic                    mem_we_d;
   logic [ADDR_W-1:0]       mem_row_d, mem_col_d;
   logic [DATA_W-1:0]       mem_wdata_d;
   logic [LAYER_W-1:0]      mem_layer_d;
   logic                    busy_d, all_done_d, error_d;
   logic [CNT_W-1:0]        write_count_d;
   logic [1:0]              err_code_d;

   logic [NUM_LAYERS-1:0]   cur_onehot;
   logic                    sel_save, sel_done, other_done;
   logic [ADDR_W-1:0]       sel_row, sel_col;
   logic [DATA_W-1:0]       sel_data;

   // Mux out the currently sequenced engine's signals
   always_comb begin
      sel_save = 1'b0;
      sel_done = 1'b0;
      sel_row  = '0;
      sel_col  = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
         if (cur_q == LAYER_W'(i)) begin
            sel_save = layer_save_enable[i];
            sel_done = layer_done[i];
            sel_row  = layer_row[i*ADDR_W +: ADDR_W];
            sel_col  = layer_col[i*ADDR_W +: ADDR_W];
            sel_data = layer_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign cur_onehot = NUM_LAYERS'(1) << cur_q;
   assign other_done = |(layer_done & ~cur_onehot);

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      wd_d          = wd_q;
      layer_start_d = '0;
      mem_we_d      = 1'b0;
      mem_row_d     = mem_row;
      mem_col_d     = mem_col;
      mem_wdata_d   = mem_wdata;
      mem_layer_d   = mem_layer;
      write_count_d = write_count;
      error_d       = error;
      err_code_d    = err_code;

      // A done from any engine other than the current one is a protocol error
      if (state_q != S_IDLE && other_done) begin
         error_d       = 1'b1;
         err_code_d[1] = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_d      = '0;
               error_d    = 1'b0;
               err_code_d = '0;
               state_d    = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            layer_start_d = cur_onehot;
            write_count_d = '0;
            wd_d          = '0;
            state_d       = S_RUN;
         end
         S_RUN: begin
            if (sel_save) begin
               mem_we_d    = 1'b1;
               mem_row_d   = sel_row;
               mem_col_d   = sel_col;
               mem_wdata_d = sel_data;
               mem_layer_d = cur_q;
               if (write_count != '1) begin
                  write_count_d = write_count + CNT_W'(1);
               end
               wd_d = '0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
            // Completion wins over a watchdog expiring in the same cycle
            if (sel_done) begin
               state_d = S_NEXT;
            end else if (!sel_save && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               error_d       = 1'b1;
               err_code_d[0] = 1'b1;
               state_d       = S_IDLE;
            end
         end
         S_NEXT: begin
            if (cur_q == LAYER_W'(NUM_LAYERS - 1)) begin
               state_d = S_FINISH;
            end else begin
               cur_d   = cur_q + LAYER_W'(1);
               state_d = S_LAUNCH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Status outputs are registered alongside the state they describe
      all_done_d = (state_d == S_FINISH);
      busy_d     = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         wd_q        <= '0;
         layer_start <= '0;
         mem_we      <= 1'b0;
         mem_row     <= '0;
         mem_col     <= '0;
         mem_wdata   <= '0;
         mem_layer   <= '0;
         busy        <= 1'b0;
         all_done    <= 1'b0;
         write_count <= '0;
         error       <= 1'b0;
         err_code    <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         wd_q        <= wd_d;
         layer_start <= layer_start_d;
         mem_we      <= mem_we_d;
         mem_row     <= mem_row_d;
         mem_col     <= mem_col_d;
         mem_wdata   <= mem_wdata_d;
         mem_layer   <= mem_layer_d;
         busy        <= busy_d;
         all_done    <= all_done_d;
         write_count <= write_count_d;
         error       <= error_d;
         err_code    <= err_code_d;
      end
   end

endmodule
